// File: rtl/ones_count_accumulator_pkg.sv
// Shared definitions for the ones-count accumulator: frame state encoding,
// popcount sample width and the sample-index width helper.
package ones_count_accumulator_pkg;

    // Each sample is the {y1,y0} output of a 3-input ones counter.
    localparam int POP_W = 2;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_e;

    // The index must reach FRAME_LEN itself, not just FRAME_LEN-1.
    function automatic int cnt_width(input int frame_len);
        return $clog2(frame_len + 1);
    endfunction

endpackage

// File: rtl/ones_count_accumulator_if.sv
// Sample-in / result-out handshake bundle of the ones-count accumulator.
// The master modport is the producer/consumer side and the slave modport is the accumulator.
interface ones_count_accumulator_if
    import ones_count_accumulator_pkg::*;
#(
    parameter int ACC_W = 8
) ();

    logic             in_valid;
    logic             in_ready;
    logic [POP_W-1:0] in_count;
    logic             sum_valid;
    logic             sum_ready;
    logic [ACC_W-1:0] sum_out;
    logic             ovf;

    modport master (
        output in_valid,
        output in_count,
        output sum_ready,
        input  in_ready,
        input  sum_valid,
        input  sum_out,
        input  ovf
    );

    modport slave (
        input  in_valid,
        input  in_count,
        input  sum_ready,
        output in_ready,
        output sum_valid,
        output sum_out,
        output ovf
    );

endinterface

// File: rtl/ones_count_accumulator_frame_counter.sv
// Sample-index counter for one frame: increments on each accepted sample,
// clears on frame restart, and flags the last sample position.
module ones_count_accumulator_frame_counter
    import ones_count_accumulator_pkg::*;
#(
    parameter int FRAME_LEN = 16,
    localparam int CNT_W    = cnt_width(FRAME_LEN)
) (
    input  logic clk,
    input  logic rst,
    input  logic inc_i,
    input  logic clr_i,
    output logic last_o
);

    logic [CNT_W-1:0] idx_q;
    logic [CNT_W-1:0] idx_d;

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        idx_d = idx_q;
        if (clr_i) begin
            idx_d = '0;
        end else if (inc_i) begin
            idx_d = idx_q + CNT_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

    assign last_o = (idx_q == CNT_W'(FRAME_LEN - 1));

endmodule

// File: rtl/ones_count_accumulator.sv
// Sums FRAME_LEN 2-bit ones counts per frame and hands the total over with valid/ready.
// Define ACC_SATURATE_EN to clamp the total at 2^ACC_W-1 on overflow instead of wrapping.
module ones_count_accumulator
    import ones_count_accumulator_pkg::*;
#(
    parameter int FRAME_LEN = 16,
    parameter int ACC_W     = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clear,
    ones_count_accumulator_if.slave   bus
);

    state_e           state_q;
    state_e           state_d;
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic             ovf_q;
    logic             ovf_d;

    logic             accept;
    logic             deliver;
    logic             frame_last;
    logic [ACC_W:0]   sum_wide;
    logic             carry;
    logic [ACC_W-1:0] acc_next;

    assign accept  = bus.in_valid && (state_q == ACCUM);
    assign deliver = bus.sum_ready && (state_q == HOLD);

    // One extra bit so the carry out of the add is the overflow indication.
    assign sum_wide = {1'b0, acc_q} + (ACC_W + 1)'(bus.in_count);
    assign carry    = sum_wide[ACC_W];

`ifdef ACC_SATURATE_EN
    assign acc_next = carry ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];
`else
    assign acc_next = sum_wide[ACC_W-1:0];
`endif

    ones_count_accumulator_frame_counter #(
        .FRAME_LEN (FRAME_LEN)
    ) u_frame_counter (
        .clk    (clk),
        .rst    (rst),
        .inc_i  (accept),
        .clr_i  (clear || deliver),
        .last_o (frame_last)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        if (clear) begin
            state_d = ACCUM;
            acc_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (accept) begin
                        acc_d = acc_next;
                        ovf_d = ovf_q || carry;
                        if (frame_last) begin
                            state_d = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (bus.sum_ready) begin
                        state_d = ACCUM;
                        acc_d   = '0;
                        ovf_d   = 1'b0;
                    end
                end
                default: begin
                    state_d = ACCUM;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ACCUM;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.in_ready  = (state_q == ACCUM);
    assign bus.sum_valid = (state_q == HOLD);
    assign bus.sum_out   = acc_q;
    assign bus.ovf       = ovf_q;

    // A held result must not move until the consumer takes it.
    a_hold_stable: assert property (
        @(posedge clk) disable iff (rst)
        (state_q == HOLD && !bus.sum_ready && !clear)
            |=> (state_q == HOLD && $stable(acc_q) && $stable(ovf_q))
    );

    a_last_ends_frame: assert property (
        @(posedge clk) disable iff (rst)
        (accept && frame_last && !clear) |=> (state_q == HOLD)
    );

    a_ready_valid_exclusive: assert property (
        @(posedge clk) disable iff (rst)
        (bus.in_ready != bus.sum_valid)
    );

endmodule
